// File: rtl/ram.sv
// =============================================================================
// Module   : ram
// Brief    : Byte-addressable RAM with internal MAR and set/store/enable
//            control. Define RAM_CLEAR_ON_RESET_EN to clear all words on reset.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a,
    input  logic              sa,
    input  logic              s,
    input  logic              e,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out
);

    logic [ADDR_W-1:0] mar_q;
    logic [ADDR_W-1:0] mar_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;

    always_comb begin
        mar_d = mar_q;
        if (sa) begin
            mar_d = a;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mar_q <= '0;
        end else begin
            mar_q <= mar_d;
        end
    end

    // Write uses the MAR value from before the edge, so sa+s together
    // store to the old location.
    assign wr_en = s & ~reset;

`ifdef RAM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[mar_q] <= d_in;
        end
    end
`else
    // No reset on the array so it can map onto block/LUT RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[mar_q] <= d_in;
        end
    end
`endif

    // Zero when disabled so several sources can be OR-combined on the bus.
    assign d_out = e ? mem_q[mar_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram.sv
// =============================================================================
// Module   : tb_ram
// Brief    : Self-checking bench for ram: directed cases plus random traffic
//            against an array-based reference model.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_ram;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic       sa;
    logic       s;
    logic       e;
    logic [7:0] d_in;
    logic [7:0] d_out;

    int n_checks;
    int n_fail;

    logic [7:0] model_mem [256];
    logic [7:0] model_mar;

    ram #(
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .sa    (sa),
        .s     (s),
        .e     (e),
        .d_in  (d_in),
        .d_out (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_read();
        return e ? model_mem[model_mar] : 8'h00;
    endfunction

    task automatic set_reset(input logic v);
        reset = v;
        if (v) begin
            model_mar = 8'h00;
`ifdef RAM_CLEAR_ON_RESET_EN
            for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
`endif
        end
    endtask

    // One rising edge; the model applies the edge rules, then we sit 1 unit past it.
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            if (s)  model_mem[model_mar] = d_in;
            if (sa) model_mar = a;
        end
        #1;
    endtask

    task automatic load_mar(input logic [7:0] addr);
        a  = addr;
        sa = 1'b1;
        step();
        sa = 1'b0;
    endtask

    task automatic store(input logic [7:0] addr, input logic [7:0] data);
        load_mar(addr);
        d_in = data;
        s    = 1'b1;
        step();
        s    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'hxx;
        model_mar = 8'h00;
        a = 8'h00; sa = 1'b0; s = 1'b0; e = 1'b0; d_in = 8'h00;
        set_reset(1'b1);
        #3;
        check("rst_dout_e0", d_out, 8'h00);
`ifdef RAM_CLEAR_ON_RESET_EN
        e = 1'b1;
        #1;
        check("rst_dout_e1_cleared", d_out, 8'h00);
        e = 1'b0;
`endif
        step();
        step();
        set_reset(1'b0);

        // Full fill, then readback in address order.
        for (int i = 0; i < 256; i++) store(i[7:0], 8'(8'hFF - i));
        for (int i = 0; i < 256; i++) begin
            load_mar(i[7:0]);
            e = 1'b1;
            #1;
            check("fill_rd", d_out, 8'(8'hFF - i));
            e = 1'b0;
            #1;
            check("fill_rd_e0", d_out, 8'h00);
        end

        // Write ordering: sa and s on the same edge.
        load_mar(8'h10);
        a = 8'h20; d_in = 8'hAB; sa = 1'b1; s = 1'b1;
        step();
        sa = 1'b0; s = 1'b0; e = 1'b1;
        #1;
        check("order_new_mar", d_out, 8'hDF);
        check("order_model", d_out, exp_read());
        load_mar(8'h10);
        check("order_old_loc", d_out, 8'hAB);
        e = 1'b0;

        // Read-during-write.
        store(8'h05, 8'h11);
        e = 1'b1; d_in = 8'h22; s = 1'b1;
        #1;
        check("rdw_before", d_out, 8'h11);
        step();
        s = 1'b0;
        check("rdw_after", d_out, 8'h22);
        e = 1'b0;

        // Mid-operation reset suppresses the write and zeroes the MAR at once.
        store(8'h01, 8'hFE);
        store(8'h00, 8'h3C);
        load_mar(8'h30);
        e = 1'b1; d_in = 8'h77; s = 1'b1;
        #1;
        set_reset(1'b1);
        #1;
        check("rst_async_mar0", d_out, exp_read());
        step();
        check("rst_no_write_loc0", d_out, exp_read());
        s = 1'b0;
        set_reset(1'b0);
        load_mar(8'h30);
        check("rst_loc30", d_out, exp_read());
        load_mar(8'h01);
        check("rst_loc01_survive", d_out, exp_read());
`ifndef RAM_CLEAR_ON_RESET_EN
        check("rst_loc01_fe", d_out, 8'hFE);
`endif
        e = 1'b0;

        // Boundary addresses must not alias.
        store(8'hFF, 8'h5A);
        store(8'h00, 8'hA5);
        e = 1'b1;
        load_mar(8'hFF);
        check("wrap_ff", d_out, 8'h5A);
        load_mar(8'h00);
        check("wrap_00", d_out, 8'hA5);
        e = 1'b0;

        // Random traffic; fill first so every location is defined in the model.
        for (int i = 0; i < 256; i++) store(i[7:0], 8'($urandom));
        for (int n = 0; n < 600; n++) begin
            a    = 8'($urandom);
            d_in = 8'($urandom);
            sa   = ($urandom_range(0, 2) == 0);
            s    = ($urandom_range(0, 2) == 0);
            e    = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_pre", d_out, exp_read());
            step();
            check("rnd_post", d_out, exp_read());
        end
        sa = 1'b0; s = 1'b0; e = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
